// File: rtl/frame_bank_scheduler_if.sv
// Upstream pixel-word stream into the frame bank scheduler: valid/ready handshake plus data.
interface frame_bank_scheduler_if #(
  parameter int DATA_W = 54
);
  logic              px_valid;
  logic              px_ready;
  logic [DATA_W-1:0] px_data;

  modport master (output px_valid, output px_data, input  px_ready);
  modport slave  (input  px_valid, input  px_data, output px_ready);
endinterface

// File: rtl/frame_bank_scheduler.sv
// Ping-pong scheduler for the two HUB75 frame RAM banks: fills the back bank from the pixel
// stream and swaps banks only at a frame boundary once the dwell has elapsed and the load is complete.
//
//   state  | meaning
//   S_LOAD | back bank being filled; stream accepted while enabled
//   S_FULL | back bank complete; waiting for frame_end with dwell expired to swap
module frame_bank_scheduler #(
  parameter int DATA_W      = 54,
  parameter int ADDR_W      = 12,
  parameter int FRAME_WORDS = 3240,
  parameter int TIMER_W     = 30
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic [TIMER_W-1:0]     i_dwell_time,
  input  logic                   i_frame_end,
  frame_bank_scheduler_if.slave  px,
  output logic                   o_wr_bank0,
  output logic                   o_wr_bank1,
  output logic [ADDR_W-1:0]      o_addr_write,
  output logic [DATA_W-1:0]      o_data_write,
  output logic                   o_rd_sel,
  output logic                   o_require_data,
  output logic                   o_frame_loaded,
  output logic                   o_swap,
  output logic                   o_underrun
);

  typedef enum logic {S_LOAD, S_FULL} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t              r_state;
  logic                r_rd_sel;
  logic [ADDR_W-1:0]   r_count;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_wr_bank0;
  logic                r_wr_bank1;
  logic [ADDR_W-1:0]   r_addr_write;
  logic [DATA_W-1:0]   r_data_write;
  logic                r_require_data;
  logic                r_frame_loaded;
  logic                r_swap;
  logic                r_underrun;

  logic w_xfer;
  logic w_frame_due;
  logic w_swap;
  logic w_underrun;

  assign px.px_ready  = i_enable & (r_state == S_LOAD);
  assign w_xfer       = px.px_valid & px.px_ready;
  assign w_frame_due  = i_enable & i_frame_end & (r_timer == '0);
  assign w_swap       = w_frame_due & (r_state == S_FULL);
  assign w_underrun   = w_frame_due & (r_state == S_LOAD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_LOAD;
      r_rd_sel       <= 1'b0;
      r_count        <= '0;
      r_timer        <= i_dwell_time;
      r_wr_bank0     <= 1'b0;
      r_wr_bank1     <= 1'b0;
      r_addr_write   <= '0;
      r_data_write   <= '0;
      r_require_data <= 1'b1;
      r_frame_loaded <= 1'b0;
      r_swap         <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      // the back bank is always the one not being displayed
      r_wr_bank0 <= w_xfer & r_rd_sel;
      r_wr_bank1 <= w_xfer & ~r_rd_sel;
      r_swap     <= w_swap;
      r_underrun <= w_underrun;

      if (w_xfer) begin
        r_addr_write <= r_count;
        r_data_write <= px.px_data;
      end

      if (w_swap)
        r_timer <= i_dwell_time;
      else if (i_enable && (r_timer != '0))
        r_timer <= r_timer - TIMER_W'(1);

      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            if (r_count == LAST_ADDR) begin
              r_count        <= '0;
              r_state        <= S_FULL;
              r_require_data <= 1'b0;
              r_frame_loaded <= 1'b1;
            end else begin
              r_count <= r_count + ADDR_W'(1);
            end
          end
        end
        S_FULL: begin
          if (w_swap) begin
            r_rd_sel       <= ~r_rd_sel;
            r_state        <= S_LOAD;
            r_require_data <= 1'b1;
            r_frame_loaded <= 1'b0;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_wr_bank0     = r_wr_bank0;
  assign o_wr_bank1     = r_wr_bank1;
  assign o_addr_write   = r_addr_write;
  assign o_data_write   = r_data_write;
  assign o_rd_sel       = r_rd_sel;
  assign o_require_data = r_require_data;
  assign o_frame_loaded = r_frame_loaded;
  assign o_swap         = r_swap;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler with a 4-word frame; cycle numbers below count
// clock edges after the reset edge (cycle 1 is the first cycle out of reset).
module tb_frame_bank_scheduler;
  localparam int DATA_W      = 54;
  localparam int ADDR_W      = 12;
  localparam int FRAME_WORDS = 4;
  localparam int TIMER_W     = 30;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_enable;
  logic [TIMER_W-1:0]  i_dwell_time;
  logic                i_frame_end;
  logic                o_wr_bank0;
  logic                o_wr_bank1;
  logic [ADDR_W-1:0]   o_addr_write;
  logic [DATA_W-1:0]   o_data_write;
  logic                o_rd_sel;
  logic                o_require_data;
  logic                o_frame_loaded;
  logic                o_swap;
  logic                o_underrun;

  int errors = 0;
  int checks = 0;

  frame_bank_scheduler_if #(.DATA_W(DATA_W)) px_if ();

  frame_bank_scheduler #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .TIMER_W(TIMER_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_dwell_time(i_dwell_time),
    .i_frame_end(i_frame_end), .px(px_if.slave),
    .o_wr_bank0(o_wr_bank0), .o_wr_bank1(o_wr_bank1), .o_addr_write(o_addr_write),
    .o_data_write(o_data_write), .o_rd_sel(o_rd_sel), .o_require_data(o_require_data),
    .o_frame_loaded(o_frame_loaded), .o_swap(o_swap), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [DATA_W-1:0] pat(input int i);
    pat = {22'h2A5A5A, 32'(i * 32'h01010101 + 32'h11)};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int dwell);
    i_rst           = 1'b1;
    i_enable        = 1'b1;
    i_frame_end     = 1'b0;
    i_dwell_time    = TIMER_W'(dwell);
    px_if.px_valid  = 1'b0;
    px_if.px_data   = '0;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(10);
    checks++; if (o_rd_sel !== 1'b0) begin errors++; $display("FAIL reset_rd_sel got=%b want=0", o_rd_sel); end
    checks++; if ({o_wr_bank0, o_wr_bank1} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b want=00", {o_wr_bank0, o_wr_bank1}); end
    checks++; if (o_addr_write !== '0 || o_data_write !== '0) begin errors++; $display("FAIL reset_addr_data got=%0h/%0h want=0/0", o_addr_write, o_data_write); end
    checks++; if ({o_swap, o_underrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b want=00", {o_swap, o_underrun}); end
    checks++; if ({o_require_data, o_frame_loaded, px_if.px_ready} !== 3'b101) begin errors++; $display("FAIL reset_status got=%b want=101", {o_require_data, o_frame_loaded, px_if.px_ready}); end
  endtask

  // continues from test_reset (cycle 1, dwell 10)
  task automatic test_load();
    px_if.px_valid = 1'b1;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      px_if.px_data = pat(i);
      tick();
      checks++; if ({o_wr_bank0, o_wr_bank1} !== 2'b01 || o_addr_write !== ADDR_W'(i)) begin errors++; $display("FAIL load_write[%0d] got strobes=%b addr=%0d want strobes=01 addr=%0d", i, {o_wr_bank0, o_wr_bank1}, o_addr_write, i); end
      checks++; if (o_data_write !== pat(i)) begin errors++; $display("FAIL load_data[%0d] got=%0h want=%0h", i, o_data_write, pat(i)); end
    end
    checks++; if ({px_if.px_ready, o_frame_loaded, o_require_data} !== 3'b010) begin errors++; $display("FAIL load_full_status got=%b want=010", {px_if.px_ready, o_frame_loaded, o_require_data}); end
    tick();
    px_if.px_valid = 1'b0;
    checks++; if ({o_wr_bank0, o_wr_bank1} !== 2'b00) begin errors++; $display("FAIL load_no_extra_write got=%b want=00", {o_wr_bank0, o_wr_bank1}); end
  endtask

  // now in cycle 6; timer during cycle k is 11-k, saturating at 0 from cycle 11
  task automatic test_swap();
    tick();
    tick();
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    checks++; if ({o_rd_sel, o_swap, o_frame_loaded} !== 3'b001) begin errors++; $display("FAIL swap_early_frame_end got=%b want=001", {o_rd_sel, o_swap, o_frame_loaded}); end
    repeat (5) tick();
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    checks++; if ({o_rd_sel, o_swap} !== 2'b11) begin errors++; $display("FAIL swap_taken got=%b want=11", {o_rd_sel, o_swap}); end
    checks++; if ({o_require_data, o_frame_loaded, px_if.px_ready} !== 3'b101) begin errors++; $display("FAIL swap_reload_status got=%b want=101", {o_require_data, o_frame_loaded, px_if.px_ready}); end
    px_if.px_valid = 1'b1;
    px_if.px_data  = pat(9);
    tick();
    px_if.px_valid = 1'b0;
    checks++; if (o_swap !== 1'b0) begin errors++; $display("FAIL swap_single_pulse got=%b want=0", o_swap); end
    checks++; if ({o_wr_bank0, o_wr_bank1} !== 2'b10 || o_addr_write !== '0) begin errors++; $display("FAIL swap_write_bank0 got strobes=%b addr=%0d want strobes=10 addr=0", {o_wr_bank0, o_wr_bank1}, o_addr_write); end
  endtask

  // dwell 3: timer reaches 0 in cycle 4
  task automatic test_underrun();
    do_reset(3);
    px_if.px_valid = 1'b1;
    px_if.px_data  = pat(0);
    tick();
    px_if.px_data  = pat(1);
    tick();
    px_if.px_valid = 1'b0;
    checks++; if (o_wr_bank1 !== 1'b1 || o_addr_write !== ADDR_W'(1)) begin errors++; $display("FAIL underrun_partial got wr1=%b addr=%0d want wr1=1 addr=1", o_wr_bank1, o_addr_write); end
    repeat (3) tick();
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    checks++; if ({o_underrun, o_rd_sel, o_swap, o_require_data} !== 4'b1001) begin errors++; $display("FAIL underrun_pulse got=%b want=1001", {o_underrun, o_rd_sel, o_swap, o_require_data}); end
    tick();
    checks++; if (o_underrun !== 1'b0) begin errors++; $display("FAIL underrun_single_pulse got=%b want=0", o_underrun); end
    px_if.px_valid = 1'b1;
    px_if.px_data  = pat(2);
    tick();
    px_if.px_data  = pat(3);
    tick();
    px_if.px_valid = 1'b0;
    checks++; if (o_addr_write !== ADDR_W'(3) || o_wr_bank1 !== 1'b1 || o_frame_loaded !== 1'b1) begin errors++; $display("FAIL underrun_finish got addr=%0d wr1=%b loaded=%b want addr=3 wr1=1 loaded=1", o_addr_write, o_wr_bank1, o_frame_loaded); end
    i_frame_end = 1'b1;
    tick();
    i_frame_end = 1'b0;
    checks++; if ({o_rd_sel, o_swap, o_underrun} !== 3'b110) begin errors++; $display("FAIL underrun_then_swap got=%b want=110", {o_rd_sel, o_swap, o_underrun}); end
  endtask

  task automatic test_valid_toggle();
    int  exp_addr;
    bit  prev_valid;
    do_reset(10);
    exp_addr   = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      px_if.px_valid = (i % 2 == 0);
      px_if.px_data  = pat(20 + i);
      prev_valid     = px_if.px_valid;
      tick();
      if (prev_valid) begin
        checks++; if (o_wr_bank1 !== 1'b1 || o_addr_write !== ADDR_W'(exp_addr) || o_data_write !== pat(20 + i)) begin errors++; $display("FAIL toggle_write[%0d] got wr1=%b addr=%0d want wr1=1 addr=%0d", i, o_wr_bank1, o_addr_write, exp_addr); end
        exp_addr++;
      end else begin
        checks++; if ({o_wr_bank0, o_wr_bank1} !== 2'b00) begin errors++; $display("FAIL toggle_idle[%0d] got=%b want=00", i, {o_wr_bank0, o_wr_bank1}); end
      end
    end
    px_if.px_valid = 1'b0;
    checks++; if (o_frame_loaded !== 1'b1) begin errors++; $display("FAIL toggle_loaded got=%b want=1", o_frame_loaded); end
  endtask

  // dwell 8, disabled in cycles 3..7: timer is 1 in cycle 13 and 0 in cycle 14
  task automatic test_enable();
    do_reset(8);
    px_if.px_valid = 1'b1;
    px_if.px_data  = pat(30);
    tick();
    px_if.px_data  = pat(31);
    tick();
    i_enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      i_frame_end = 1'b1;
      tick();
      checks++; if ({o_wr_bank0, o_wr_bank1, px_if.px_ready, o_underrun} !== 4'b0000) begin errors++; $display("FAIL enable_frozen[%0d] got=%b want=0000", j, {o_wr_bank0, o_wr_bank1, px_if.px_ready, o_underrun}); end
    end
    i_frame_end = 1'b0;
    i_enable    = 1'b1;
    px_if.px_data = pat(32);
    tick();
    checks++; if (o_wr_bank1 !== 1'b1 || o_addr_write !== ADDR_W'(2) || o_data_write !== pat(32)) begin errors++; $display("FAIL enable_resume got wr1=%b addr=%0d want wr1=1 addr=2", o_wr_bank1, o_addr_write); end
    px_if.px_data = pat(33);
    tick();
    px_if.px_valid = 1'b0;
    checks++; if (o_addr_write !== ADDR_W'(3) || o_frame_loaded !== 1'b1) begin errors++; $display("FAIL enable_loaded got addr=%0d loaded=%b want addr=3 loaded=1", o_addr_write, o_frame_loaded); end
    repeat (3) tick();
    i_frame_end = 1'b1;
    tick();
    checks++; if ({o_rd_sel, o_swap} !== 2'b00) begin errors++; $display("FAIL enable_timer_held got=%b want=00", {o_rd_sel, o_swap}); end
    tick();
    i_frame_end = 1'b0;
    checks++; if ({o_rd_sel, o_swap} !== 2'b11) begin errors++; $display("FAIL enable_swap got=%b want=11", {o_rd_sel, o_swap}); end
  endtask

  // continues with o_rd_sel = 1, so bank 0 is the back bank
  task automatic test_reset_midload();
    px_if.px_valid = 1'b1;
    px_if.px_data  = pat(40);
    tick();
    checks++; if ({o_wr_bank0, o_wr_bank1} !== 2'b10 || o_addr_write !== '0) begin errors++; $display("FAIL midload_bank0 got strobes=%b addr=%0d want strobes=10 addr=0", {o_wr_bank0, o_wr_bank1}, o_addr_write); end
    px_if.px_data  = pat(41);
    tick();
    do_reset(10);
    checks++; if ({o_rd_sel, o_wr_bank0, o_wr_bank1, o_require_data} !== 4'b0001) begin errors++; $display("FAIL midload_reset got=%b want=0001", {o_rd_sel, o_wr_bank0, o_wr_bank1, o_require_data}); end
    checks++; if (o_addr_write !== '0 || o_data_write !== '0) begin errors++; $display("FAIL midload_reset_bus got=%0h/%0h want=0/0", o_addr_write, o_data_write); end
    px_if.px_valid = 1'b1;
    px_if.px_data  = pat(42);
    tick();
    px_if.px_valid = 1'b0;
    checks++; if ({o_wr_bank0, o_wr_bank1} !== 2'b01 || o_addr_write !== '0 || o_data_write !== pat(42)) begin errors++; $display("FAIL midload_new_load got strobes=%b addr=%0d want strobes=01 addr=0", {o_wr_bank0, o_wr_bank1}, o_addr_write); end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_wr_bank0 && o_wr_bank1) begin
      errors++;
      $display("FAIL both_strobes got=11 want at most one");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst          = 1'b1;
    i_enable       = 1'b0;
    i_frame_end    = 1'b0;
    i_dwell_time   = '0;
    px_if.px_valid = 1'b0;
    px_if.px_data  = '0;
    test_reset();
    test_load();
    test_swap();
    test_underrun();
    test_valid_toggle();
    test_enable();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
